// File: rtl/tinyqv_serial_regfile_pkg.sv
// Shared types and constants for the nibble-serial TinyQV datapath.
package tinyqv_pkg;

    localparam int NIBBLES_PER_WORD = 8;
    localparam int NIB_BITS         = 3;
    localparam int NUM_REGS_E       = 16;
    localparam int WORD_BITS        = NIBBLES_PER_WORD * 4;

    typedef logic [3:0] reg_idx_t;
    typedef logic [3:0] nibble_t;

    localparam reg_idx_t REG_X0 = 4'd0;

endpackage

// File: rtl/tinyqv_serial_regfile_if.sv
// Operand/result stream between the serial register file and its controller/ALU.
interface tinyqv_serial_regfile_if;
    import tinyqv_pkg::*;

    logic                start;
    reg_idx_t            rs1;
    reg_idx_t            rs2;
    reg_idx_t            rd;
    logic                wr_en;
    nibble_t             rd_nibble;
    nibble_t             rs1_nibble;
    nibble_t             rs2_nibble;
    logic [NIB_BITS-1:0] nib;
    logic                busy;
    logic                first;
    logic                last;

    modport master (
        output start, rs1, rs2, rd, wr_en, rd_nibble,
        input  rs1_nibble, rs2_nibble, nib, busy, first, last
    );

    modport slave (
        input  start, rs1, rs2, rd, wr_en, rd_nibble,
        output rs1_nibble, rs2_nibble, nib, busy, first, last
    );

endinterface

// File: rtl/tinyqv_nibble_mux.sv
// Selects one 4-bit slice of a 32-bit word by nibble slot.
module tinyqv_nibble_mux
    import tinyqv_pkg::*;
(
    input  logic [WORD_BITS-1:0] i_word,
    input  logic [NIB_BITS-1:0]  i_nib,
    output nibble_t              o_nibble
);

    assign o_nibble = i_word[{i_nib, 2'b00} +: 4];

endmodule

// File: rtl/tinyqv_serial_regfile.sv
// RV32E register file streaming rs1/rs2 and absorbing rd one nibble per clock, 8 clocks per op.
module tinyqv_serial_regfile
    import tinyqv_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_E,
    parameter int ADDR_BITS = 4
) (
    input logic                    clk,
    input logic                    rstn,
    tinyqv_serial_regfile_if.slave io_bus
);

    localparam logic [0:0]          ST_IDLE  = 1'b0;
    localparam logic [0:0]          ST_RUN   = 1'b1;
    localparam logic [NIB_BITS-1:0] NIB_LAST = NIB_BITS'(NIBBLES_PER_WORD - 1);

    logic [0:0]           r_state;
    logic [NIB_BITS-1:0]  r_nib;
    logic [ADDR_BITS-1:0] r_rs1;
    logic [ADDR_BITS-1:0] r_rs2;
    logic [ADDR_BITS-1:0] r_rd;
    logic                 r_wr_en;
    logic [WORD_BITS-1:0] r_regs [1:NUM_REGS-1];

    logic                 w_busy;
    logic                 w_at_last;
    logic                 w_accept;
    logic                 w_wr_fire;
    logic [WORD_BITS-1:0] w_rs1_word;
    logic [WORD_BITS-1:0] w_rs2_word;

    assign w_busy    = (r_state == ST_RUN);
    assign w_at_last = (r_nib == NIB_LAST);
    // A new op is only taken between ops, which makes slot-7 chaining bubble-free.
    assign w_accept  = io_bus.start & (~w_busy | w_at_last);
    assign w_wr_fire = w_busy & r_wr_en & (r_rd != REG_X0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_nib   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_wr_en <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs1   <= io_bus.rs1;
                r_rs2   <= io_bus.rs2;
                r_rd    <= io_bus.rd;
                r_wr_en <= io_bus.wr_en;
            end
            if (!w_busy) begin
                r_nib <= '0;
                if (io_bus.start) r_state <= ST_RUN;
            end else if (w_at_last) begin
                r_nib <= '0;
                if (!io_bus.start) r_state <= ST_IDLE;
            end else begin
                r_nib <= r_nib + 1'b1;
            end
        end
    end

    // NOTE: the register array is deliberately not reset; only the control state is.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_regs[r_rd][{r_nib, 2'b00} +: 4] <= io_bus.rd_nibble;
    end

    // NOTE: defaults first so no path through this block leaves a word unassigned (no latch).
    always_comb begin
        w_rs1_word = '0;
        w_rs2_word = '0;
        if (r_rs1 != REG_X0) w_rs1_word = r_regs[r_rs1];
        if (r_rs2 != REG_X0) w_rs2_word = r_regs[r_rs2];
    end

    tinyqv_nibble_mux u_rs1_mux (
        .i_word   (w_rs1_word),
        .i_nib    (r_nib),
        .o_nibble (io_bus.rs1_nibble)
    );

    tinyqv_nibble_mux u_rs2_mux (
        .i_word   (w_rs2_word),
        .i_nib    (r_nib),
        .o_nibble (io_bus.rs2_nibble)
    );

    assign io_bus.nib   = r_nib;
    assign io_bus.busy  = w_busy;
    assign io_bus.first = w_busy & (r_nib == '0);
    assign io_bus.last  = w_busy & w_at_last;

endmodule
